// File: rtl/tt_mux_sel_driver.sv
// tt_mux_sel_driver: drives the design-select mux of a shuttle chip.
// A select request resets the mux select counter, then issues req_addr
// increment pulses, and then applies the requested enable. Out-of-range
// addresses are rejected at once with done+err and nothing is disturbed.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; req_ready high, ctrl_sel_rst_n high
// RST    | select counter held in reset for PULSE_CYC cycles, ena low
// GAP    | reset released, no increment, PULSE_CYC cycles
// INC_HI | increment pulse high phase, PULSE_CYC cycles
// INC_LO | increment pulse low phase, PULSE_CYC cycles
// FIN    | single cycle: done pulse, err on reject, ena/cur_addr applied
`timescale 1ns/1ps
module tt_mux_sel_driver #(
  parameter int ADDR_W      = 9,
  parameter int NUM_DESIGNS = 250,
  parameter int PULSE_CYC   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int PH_W = $clog2(PULSE_CYC + 1);
  localparam logic [PH_W-1:0]   PH_LOAD = PH_W'(PULSE_CYC - 1);
  localparam logic [ADDR_W:0]   NUM_D   = (ADDR_W + 1)'(NUM_DESIGNS);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_INC_HI = 3'd3;
  localparam logic [2:0] S_INC_LO = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] inc_cnt_q, inc_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ena_cap_q, ena_cap_d;
  logic              bad_q, bad_d;

  logic              req_ready_q, req_ready_d;
  logic              sel_rst_n_q, sel_rst_n_d;
  logic              sel_inc_q, sel_inc_d;
  logic              ctrl_ena_q, ctrl_ena_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

  logic accept;
  logic addr_bad;
  logic phase_tc;

  // Acceptance only from IDLE once req_ready is visible, so the first edge
  // after reset release can never take a request.
  assign accept   = (state_q == S_IDLE) && req_ready_q && req_valid;
  assign addr_bad = ({1'b0, req_addr} >= NUM_D);
  assign phase_tc = (phase_q == '0);

  // Sequencer next state: phase timer is a down-counter reloaded on every
  // state change; inc_cnt counts remaining increment pulses.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    inc_cnt_d = inc_cnt_q;
    addr_d    = addr_q;
    ena_cap_d = ena_cap_q;
    bad_d     = bad_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = req_addr;
          ena_cap_d = req_ena;
          bad_d     = addr_bad;
          inc_cnt_d = req_addr;
          phase_d   = PH_LOAD;
          state_d   = addr_bad ? S_FIN : S_RST;
        end
      end
      S_RST: begin
        if (phase_tc) begin
          state_d = S_GAP;
          phase_d = PH_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      S_GAP: begin
        if (phase_tc) begin
          state_d = (inc_cnt_q == '0) ? S_FIN : S_INC_HI;
          phase_d = PH_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      S_INC_HI: begin
        if (phase_tc) begin
          state_d = S_INC_LO;
          phase_d = PH_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      S_INC_LO: begin
        if (phase_tc) begin
          inc_cnt_d = inc_cnt_q - ONE_A;
          state_d   = (inc_cnt_q == ONE_A) ? S_FIN : S_INC_HI;
          phase_d   = PH_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so every
  // output changes on the same edge as the state and nothing is combinational.
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    sel_rst_n_d = (state_d != S_RST);
    sel_inc_d   = (state_d == S_INC_HI);
    done_d      = (state_d == S_FIN);
    err_d       = (state_d == S_FIN) && bad_d;
    ctrl_ena_d  = ctrl_ena_q;
    cur_addr_d  = cur_addr_q;
    if (state_d == S_RST) begin
      ctrl_ena_d = 1'b0;
    end else if ((state_d == S_FIN) && !bad_d) begin
      ctrl_ena_d = ena_cap_d;
      cur_addr_d = addr_d;
    end
  end

  // State, counters, captured request and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      inc_cnt_q   <= '0;
      addr_q      <= '0;
      ena_cap_q   <= 1'b0;
      bad_q       <= 1'b0;
      req_ready_q <= 1'b0;
      sel_rst_n_q <= 1'b0;
      sel_inc_q   <= 1'b0;
      ctrl_ena_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      inc_cnt_q   <= inc_cnt_d;
      addr_q      <= addr_d;
      ena_cap_q   <= ena_cap_d;
      bad_q       <= bad_d;
      req_ready_q <= req_ready_d;
      sel_rst_n_q <= sel_rst_n_d;
      sel_inc_q   <= sel_inc_d;
      ctrl_ena_q  <= ctrl_ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cur_addr_q  <= cur_addr_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = sel_inc_q;
  assign ctrl_ena       = ctrl_ena_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign cur_addr       = cur_addr_q;

endmodule

// File: tb/tb_tt_mux_sel_driver.sv
// Bench for tt_mux_sel_driver: a mux select-counter model plus expected
// timing derived from the pulse rules (reset P, gap P, 2P per increment).
`timescale 1ns/1ps
module tb_tt_mux_sel_driver;

  localparam int P = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // P=2 instance
  logic v = 1'b0, ena = 1'b0;
  logic [8:0] addr = '0;
  logic rdy, srst, inc, cena, busy, done, err;
  logic [8:0] cur;
  // P=1 instance
  logic v1 = 1'b0, ena1 = 1'b0;
  logic [8:0] addr1 = '0;
  logic rdy1, srst1, inc1, cena1, busy1, done1, err1;
  logic [8:0] cur1;

  int n_cmp = 0;
  int n_err = 0;

  int exp_cur = 0;
  logic exp_cena = 1'b0;

  // mux select-counter models: level reset, count on rising increment
  int mux0 = 0, mux1 = 0;
  logic pinc0 = 1'b0, pinc1 = 1'b0;
  int viol1 = 0;

  // observation results
  int m_done_off, m_err, m_cena, m_cur, m_rst_cnt, m_rst_first, m_rst_last;
  int m_pulses, m_hi_min, m_hi_max, m_lo_min, m_lo_max, m_viol, m_ena_busy;
  int m_post_busy, m_post_rdy, m_mux;

  tt_mux_sel_driver #(.ADDR_W(9), .NUM_DESIGNS(250), .PULSE_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(v), .req_ready(rdy),
    .req_addr(addr), .req_ena(ena), .ctrl_sel_rst_n(srst), .ctrl_sel_inc(inc),
    .ctrl_ena(cena), .busy(busy), .done(done), .err(err), .cur_addr(cur));

  tt_mux_sel_driver #(.ADDR_W(9), .NUM_DESIGNS(250), .PULSE_CYC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_ready(rdy1),
    .req_addr(addr1), .req_ena(ena1), .ctrl_sel_rst_n(srst1), .ctrl_sel_inc(inc1),
    .ctrl_ena(cena1), .busy(busy1), .done(done1), .err(err1), .cur_addr(cur1));

  always #5 clk = ~clk;

  // mux models sampled mid-cycle
  always @(negedge clk) begin
    if (srst !== 1'b1) mux0 = 0;
    else if (inc === 1'b1 && pinc0 !== 1'b1) mux0 = mux0 + 1;
    pinc0 = inc;
    if (srst1 !== 1'b1) mux1 = 0;
    else if (inc1 === 1'b1 && pinc1 !== 1'b1) mux1 = mux1 + 1;
    pinc1 = inc1;
    if (inc1 === 1'b1 && srst1 !== 1'b1) viol1 = viol1 + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // present a request and return right after its accept edge
  task automatic send(input logic [8:0] a, input logic e);
    int t;
    t = 0;
    @(negedge clk);
    v = 1'b1; addr = a; ena = e;
    while (rdy !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      n_cmp++; n_err++;
      $display("FAIL send_ready: got ready=%0b expected 1", rdy);
    end
    @(posedge clk);
  endtask

  // watch the outputs cycle by cycle after an accept until done
  task automatic observe(input int budget);
    int hw, lw;
    logic prev;
    hw = 0; lw = 0; prev = 1'b0;
    m_done_off = -1; m_err = -1; m_cena = -1; m_cur = -1;
    m_rst_cnt = 0; m_rst_first = 0; m_rst_last = 0; m_pulses = 0;
    m_hi_min = 1000; m_hi_max = 0; m_lo_min = 1000; m_lo_max = 0;
    m_viol = 0; m_ena_busy = 0;
    for (int off = 1; off <= budget; off++) begin
      @(negedge clk);
      if (off == 1) v = 1'b0;
      if (srst === 1'b0) begin
        m_rst_cnt++;
        if (m_rst_first == 0) m_rst_first = off;
        m_rst_last = off;
      end
      if (inc === 1'b1 && srst !== 1'b1) m_viol++;
      if (inc === 1'b1) begin
        if (!prev) begin
          m_pulses++;
          if (m_pulses > 1) begin
            if (lw < m_lo_min) m_lo_min = lw;
            if (lw > m_lo_max) m_lo_max = lw;
          end
          hw = 0;
        end
        hw++;
      end else begin
        if (prev) begin
          if (hw < m_hi_min) m_hi_min = hw;
          if (hw > m_hi_max) m_hi_max = hw;
          lw = 0;
        end
        lw++;
      end
      prev = (inc === 1'b1);
      if (done === 1'b1) begin
        m_done_off = off; m_err = err; m_cena = cena; m_cur = cur;
        break;
      end else if (cena !== 1'b0) begin
        m_ena_busy++;
      end
    end
    @(negedge clk);
    #1;
    m_post_busy = busy; m_post_rdy = rdy; m_mux = mux0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rdy, srst, inc, cena, busy, done, err} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_outputs: got %b expected 0000000", {rdy, srst, inc, cena, busy, done, err});
    end
    n_cmp++;
    if (cur !== 9'd0) begin n_err++; $display("FAIL rst_cur: got %0d expected 0", cur); end
    n_cmp++;
    if ({rdy1, srst1, inc1, cena1, busy1, done1, err1} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_outputs_p1: got %b expected 0000000", {rdy1, srst1, inc1, cena1, busy1, done1, err1});
    end
    // request already pending when reset lifts must not be taken on the first edge
    v = 1'b1; addr = 9'd0; ena = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, rdy, srst} !== 3'b011) begin
      n_err++;
      $display("FAIL rst_first_edge: got busy/rdy/srst=%b expected 011", {busy, rdy, srst});
    end
    v = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_no_accept: got busy/done=%b expected 00", {busy, done});
    end
    exp_cur = 0; exp_cena = 1'b0;
  endtask

  task automatic test_addr0();
    send(9'd0, 1'b1);
    observe(20);
    n_cmp++;
    if (m_done_off !== 1 + 2*P) begin n_err++; $display("FAIL a0_done_cycle: got %0d expected %0d", m_done_off, 1 + 2*P); end
    n_cmp++;
    if (m_rst_cnt !== P || m_rst_first !== 1 || m_rst_last !== P) begin
      n_err++;
      $display("FAIL a0_rst_window: got cnt=%0d first=%0d last=%0d expected %0d/1/%0d", m_rst_cnt, m_rst_first, m_rst_last, P, P);
    end
    n_cmp++;
    if (m_pulses !== 0) begin n_err++; $display("FAIL a0_pulses: got %0d expected 0", m_pulses); end
    n_cmp++;
    if (m_cena !== 1 || m_err !== 0 || m_cur !== 0) begin
      n_err++;
      $display("FAIL a0_fin: got ena=%0d err=%0d cur=%0d expected 1/0/0", m_cena, m_err, m_cur);
    end
    n_cmp++;
    if (m_ena_busy !== 0) begin n_err++; $display("FAIL a0_ena_low: got %0d cycles high expected 0", m_ena_busy); end
    n_cmp++;
    if (m_post_busy !== 0 || m_post_rdy !== 1 || m_mux !== 0) begin
      n_err++;
      $display("FAIL a0_after: got busy=%0d rdy=%0d mux=%0d expected 0/1/0", m_post_busy, m_post_rdy, m_mux);
    end
    exp_cur = 0; exp_cena = 1'b1;
  endtask

  task automatic test_addr3();
    send(9'd3, 1'b1);
    observe(40);
    n_cmp++;
    if (m_done_off !== 17) begin n_err++; $display("FAIL a3_done_cycle: got %0d expected 17", m_done_off); end
    n_cmp++;
    if (m_pulses !== 3) begin n_err++; $display("FAIL a3_pulses: got %0d expected 3", m_pulses); end
    n_cmp++;
    if (m_hi_min !== P || m_hi_max !== P || m_lo_min !== P || m_lo_max !== P) begin
      n_err++;
      $display("FAIL a3_widths: got hi %0d..%0d lo %0d..%0d expected all %0d", m_hi_min, m_hi_max, m_lo_min, m_lo_max, P);
    end
    n_cmp++;
    if (m_viol !== 0) begin n_err++; $display("FAIL a3_inc_in_rst: got %0d expected 0", m_viol); end
    n_cmp++;
    if (m_cur !== 3 || m_cena !== 1 || m_mux !== 3) begin
      n_err++;
      $display("FAIL a3_fin: got cur=%0d ena=%0d mux=%0d expected 3/1/3", m_cur, m_cena, m_mux);
    end
    exp_cur = 3; exp_cena = 1'b1;
  endtask

  task automatic test_invalid();
    send(9'd250, 1'b0);
    observe(10);
    n_cmp++;
    if (m_done_off !== 1 || m_err !== 1) begin
      n_err++;
      $display("FAIL inv_done: got off=%0d err=%0d expected 1/1", m_done_off, m_err);
    end
    n_cmp++;
    if (m_cena !== exp_cena || m_cur !== exp_cur || m_mux !== exp_cur) begin
      n_err++;
      $display("FAIL inv_unchanged: got ena=%0d cur=%0d mux=%0d expected %0d/%0d/%0d", m_cena, m_cur, m_mux, exp_cena, exp_cur, exp_cur);
    end
    n_cmp++;
    if (m_rst_cnt !== 0 || m_pulses !== 0) begin
      n_err++;
      $display("FAIL inv_quiet: got rst_low=%0d pulses=%0d expected 0/0", m_rst_cnt, m_pulses);
    end
    n_cmp++;
    if (m_post_rdy !== 1) begin n_err++; $display("FAIL inv_idle: got rdy=%0d expected 1", m_post_rdy); end
  endtask

  task automatic test_back_to_back();
    int first, second, acc2, c1, e1;
    first = -1; second = -1; acc2 = -1; c1 = -1; e1 = -1;
    send(9'd2, 1'b0);
    for (int off = 1; off <= 80; off++) begin
      @(negedge clk);
      if (off == 1) begin addr = 9'd5; ena = 1'b1; end
      if (acc2 >= 0 && off == acc2 + 1) v = 1'b0;
      if (rdy === 1'b1 && v === 1'b1 && acc2 < 0) acc2 = off;
      if (done === 1'b1) begin
        if (first < 0) begin
          first = off; c1 = cur; e1 = cena;
        end else begin
          second = off;
          break;
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (first !== 13 || c1 !== 2 || e1 !== 0) begin
      n_err++;
      $display("FAIL b2b_first: got off=%0d cur=%0d ena=%0d expected 13/2/0", first, c1, e1);
    end
    n_cmp++;
    if (acc2 !== 14) begin n_err++; $display("FAIL b2b_ready: got %0d expected 14", acc2); end
    n_cmp++;
    if (second !== 39) begin n_err++; $display("FAIL b2b_second: got %0d expected 39", second); end
    n_cmp++;
    if (mux0 !== 5 || cur !== 9'd5 || cena !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_final: got mux=%0d cur=%0d ena=%0d expected 5/5/1", mux0, cur, cena);
    end
    exp_cur = 5; exp_cena = 1'b1;
  endtask

  task automatic test_reset_mid();
    int found, dn;
    logic prev;
    found = 0; dn = 0; prev = 1'b0;
    send(9'd7, 1'b1);
    for (int off = 1; off <= 40; off++) begin
      @(negedge clk);
      if (off == 1) v = 1'b0;
      if (prev && inc === 1'b0) begin found = 1; break; end
      prev = (inc === 1'b1);
    end
    n_cmp++;
    if (found !== 1) begin n_err++; $display("FAIL mid_inc_lo: got %0d expected 1", found); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy, srst, inc, cena, busy, done, err} !== 7'b0 || cur !== 9'd0) begin
      n_err++;
      $display("FAIL mid_async: got %b cur=%0d expected 0000000 cur=0", {rdy, srst, inc, cena, busy, done, err}, cur);
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d expected 0", dn); end
    send(9'd4, 1'b1);
    observe(40);
    n_cmp++;
    if (m_done_off !== 21 || m_cur !== 4 || m_cena !== 1 || m_mux !== 4) begin
      n_err++;
      $display("FAIL mid_fresh: got off=%0d cur=%0d ena=%0d mux=%0d expected 21/4/1/4", m_done_off, m_cur, m_cena, m_mux);
    end
    exp_cur = 4; exp_cena = 1'b1;
  endtask

  task automatic test_random();
    int a, e, bad, exp_off, exp_ec;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom_range(250, 511);
      else a = $urandom_range(0, 15);
      e = $urandom_range(0, 1);
      bad = (a >= 250);
      exp_off = bad ? 1 : 1 + 2*P + 2*P*a;
      exp_ec = bad ? int'(exp_cena) : e;
      send(9'(a), 1'(e));
      observe(exp_off + 8);
      n_cmp++;
      if (m_done_off !== exp_off || m_err !== bad) begin
        n_err++;
        $display("FAIL rnd_done a=%0d: got off=%0d err=%0d expected %0d/%0d", a, m_done_off, m_err, exp_off, bad);
      end
      if (!bad) begin
        exp_cur = a; exp_cena = 1'(e);
      end
      n_cmp++;
      if (m_cena !== exp_ec || m_cur !== exp_cur || m_mux !== exp_cur) begin
        n_err++;
        $display("FAIL rnd_result a=%0d: got ena=%0d cur=%0d mux=%0d expected %0d/%0d/%0d", a, m_cena, m_cur, m_mux, exp_ec, exp_cur, exp_cur);
      end
      n_cmp++;
      if (m_pulses !== (bad ? 0 : a) || m_rst_cnt !== (bad ? 0 : P) || m_viol !== 0) begin
        n_err++;
        $display("FAIL rnd_wave a=%0d: got pulses=%0d rst_low=%0d viol=%0d expected %0d/%0d/0", a, m_pulses, m_rst_cnt, m_viol, bad ? 0 : a, bad ? 0 : P);
      end
      if (!bad && a > 1) begin
        n_cmp++;
        if (m_hi_min !== P || m_hi_max !== P || m_lo_min !== P || m_lo_max !== P || m_ena_busy !== 0) begin
          n_err++;
          $display("FAIL rnd_widths a=%0d: got hi %0d..%0d lo %0d..%0d ena_busy=%0d expected %0d, 0", a, m_hi_min, m_hi_max, m_lo_min, m_lo_max, m_ena_busy, P);
        end
      end
    end
  endtask

  task automatic test_p1_max();
    int t, off_done;
    t = 0; off_done = -1;
    @(negedge clk);
    v1 = 1'b1; addr1 = 9'd249; ena1 = 1'b1;
    while (rdy1 !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) begin
      n_cmp++; n_err++;
      $display("FAIL p1_ready: got ready=%0b expected 1", rdy1);
    end
    viol1 = 0;
    @(posedge clk);
    for (int off = 1; off <= 700; off++) begin
      @(negedge clk);
      if (off == 1) v1 = 1'b0;
      if (done1 === 1'b1) begin off_done = off; break; end
    end
    n_cmp++;
    if (off_done !== 501 || err1 !== 1'b0) begin
      n_err++;
      $display("FAIL p1_done: got off=%0d err=%0d expected 501/0", off_done, err1);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (mux1 !== 249 || cur1 !== 9'd249 || cena1 !== 1'b1 || viol1 !== 0) begin
      n_err++;
      $display("FAIL p1_result: got mux=%0d cur=%0d ena=%0d viol=%0d expected 249/249/1/0", mux1, cur1, cena1, viol1);
    end
  endtask

  initial begin
    test_reset();
    test_addr0();
    test_addr3();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_p1_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
